// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB types and constants for the completion-side broadcaster and its snoopers.
package cdb_broadcaster_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned ROB_LEN        = 32;
  localparam int unsigned TAG_W          = $clog2(ROB_LEN);
  localparam int unsigned CDB_NUM_CH     = 4;
  localparam int unsigned CDB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             valid;
  } TAG_PACKET;

  typedef struct packed {
    TAG_PACKET       reg_tag;
    logic [XLEN-1:0] reg_value;
  } CDB_PACKET;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } CDB_ENTRY;

endpackage

// File: rtl/cdb_broadcaster_fifo.sv
// Depth-N synchronous FIFO of CDB entries with occupancy count and synchronous flush.
module cdb_fifo
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  CDB_ENTRY               push_data,
  input  logic                   pop,
  output CDB_ENTRY               head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  CDB_ENTRY         mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok = push && (count_q != CNT_W'(DEPTH));
    pop_ok  = pop && (count_q != '0);
    head    = mem_q[rd_q];
    count   = count_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only consumed while the count is non-zero.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Round-robin CDB broadcaster over per-channel completion FIFOs.
// Define CDB_BYPASS_EN to let an empty channel's input win directly (1-cycle latency).
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned NUM_CH     = CDB_NUM_CH,
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [NUM_CH-1:0]              fu_valid,
  input  logic [NUM_CH-1:0][TAG_W-1:0]   fu_tag,
  input  logic [NUM_CH-1:0][XLEN-1:0]    fu_value,
  output logic [NUM_CH-1:0]              fu_ready,
  output CDB_PACKET                      cdb_packet_out,
  output logic [$clog2(NUM_CH)-1:0]      grant_ch
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]  count [NUM_CH];
  CDB_ENTRY          head  [NUM_CH];
  logic [NUM_CH-1:0] fifo_empty, accept, bypass_ok, cand, push, pop;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d, winner;
  logic              found, use_bypass;
  CDB_ENTRY          win_entry;

  // Ready is a function of registered occupancy only.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      fifo_empty[i] = (count[i] == '0);
      fu_ready[i]   = (count[i] < CNT_W'(FIFO_DEPTH));
    end
    accept = fu_valid & fu_ready & {NUM_CH{~squash}};
  end

`ifdef CDB_BYPASS_EN
  assign bypass_ok = fifo_empty & accept;
`else
  assign bypass_ok = '0;
`endif

  assign cand = (~fifo_empty | bypass_ok) & {NUM_CH{~squash}};

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned idx;
      idx = rr_ptr_q + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && cand[CH_W'(idx)]) begin
        found  = 1'b1;
        winner = CH_W'(idx);
      end
    end
  end

  // A winner with an empty FIFO can only be a bypass candidate.
  always_comb begin
    use_bypass = found && fifo_empty[winner];
    win_entry  = use_bypass ? CDB_ENTRY'{tag: fu_tag[winner], value: fu_value[winner]}
                            : head[winner];
    rr_ptr_d   = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      push[i] = accept[i] && !(use_bypass && (winner == CH_W'(i)));
      pop[i]  = found && !use_bypass && (winner == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    cdb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (squash),
      .push      (push[g]),
      .push_data (CDB_ENTRY'{tag: fu_tag[g], value: fu_value[g]}),
      .pop       (pop[g]),
      .head      (head[g]),
      .count     (count[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q       <= '0;
      cdb_packet_out <= '0;
      grant_ch       <= '0;
    end else if (squash) begin
      rr_ptr_q       <= '0;
      cdb_packet_out <= '0;
    end else if (found) begin
      rr_ptr_q                     <= rr_ptr_d;
      cdb_packet_out.reg_tag.valid <= 1'b1;
      cdb_packet_out.reg_tag.tag   <= win_entry.tag;
      cdb_packet_out.reg_value     <= win_entry.value;
      grant_ch                     <= winner;
    end else begin
      cdb_packet_out <= '0;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: per-channel expected queues checked by a negedge monitor.
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  localparam int NCH = 4;
`ifdef CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  logic                        squash = 1'b0;
  logic [NCH-1:0]              fu_valid = '0;
  logic [NCH-1:0][TAG_W-1:0]   fu_tag = '0;
  logic [NCH-1:0][XLEN-1:0]    fu_value = '0;
  logic [NCH-1:0]              fu_ready;
  CDB_PACKET                   cdb_packet_out;
  logic [1:0]                  grant_ch;

  int       n_tests = 0;
  int       n_fail = 0;
  CDB_ENTRY exp_q [NCH][$];
  int       exp_grant[$];
  int       mon_ch;
  CDB_ENTRY mon_e;
  int       seq [NCH];
  logic     saw_full;

  cdb_broadcaster dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .fu_valid       (fu_valid),
    .fu_tag         (fu_tag),
    .fu_value       (fu_value),
    .fu_ready       (fu_ready),
    .cdb_packet_out (cdb_packet_out),
    .grant_ch       (grant_ch)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic all_empty();
    for (int i = 0; i < NCH; i++) if (exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic offer(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    fu_valid[ch] = 1'b1;
    fu_tag[ch]   = tag;
    fu_value[ch] = val;
  endtask

  // One clock: record accepted inputs, keep unaccepted ones held, model squash flush.
  task automatic step();
    logic [NCH-1:0] acc;
    acc = fu_valid & fu_ready & {NCH{~squash}};
    for (int i = 0; i < NCH; i++)
      if (acc[i]) exp_q[i].push_back(CDB_ENTRY'{tag: fu_tag[i], value: fu_value[i]});
    @(posedge clock);
    #1;
    if (squash) begin
      squash   = 1'b0;
      fu_valid = '0;
      for (int i = 0; i < NCH; i++) exp_q[i].delete();
    end else begin
      fu_valid = fu_valid & ~acc;
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 60 && !all_empty(); c++) step();
    check(name, {63'd0, all_empty()}, 64'd1);
    step();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset    = 1'b0;
    squash   = 1'b0;
    fu_valid = '0;
    #2;
    check("reset_async_pkt", cdb_packet_out, '0);
    for (int i = 0; i < NCH; i++) exp_q[i].delete();
    exp_grant.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_pkt", cdb_packet_out, '0);
    check("reset_grant", grant_ch, 0);
    check("reset_ready", fu_ready, 4'hF);
  endtask

  always @(negedge clock) begin
    if (reset && cdb_packet_out.reg_tag.valid) begin
      mon_ch = int'(grant_ch);
      if (exp_q[mon_ch].size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_bcast: ch %0d tag %0h value %0h, expected no broadcast",
                 mon_ch, cdb_packet_out.reg_tag.tag, cdb_packet_out.reg_value);
      end else begin
        mon_e = exp_q[mon_ch].pop_front();
        check("bcast_tag", cdb_packet_out.reg_tag.tag, mon_e.tag);
        check("bcast_value", cdb_packet_out.reg_value, mon_e.value);
      end
      if (exp_grant.size() > 0) check("grant_order", grant_ch, exp_grant.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    do_reset();

    // Single result on channel 2, one-cycle pulse.
    offer(2, 5'd5, 32'hDEAD);
    step();
    @(negedge clock);
    check("single_valid_e1", cdb_packet_out.reg_tag.valid, BYP);
    step();
    @(negedge clock);
    check("single_valid_e2", cdb_packet_out.reg_tag.valid, !BYP);
    step();
    @(negedge clock);
    check("single_valid_e3", cdb_packet_out.reg_tag.valid, 1'b0);
    check("single_grant_hold", grant_ch, 2);

    // Tag 0 is a real tag; surrounding idle cycles stay invalid.
    check("tag0_idle_before", cdb_packet_out.reg_tag.valid, 1'b0);
    offer(0, 5'd0, 32'd7);
    step();
    @(negedge clock);
    check("tag0_valid_e1", cdb_packet_out.reg_tag.valid, BYP);
    step();
    @(negedge clock);
    check("tag0_valid_e2", cdb_packet_out.reg_tag.valid, !BYP);
    check("tag0_tag", cdb_packet_out.reg_tag.tag, 0);
    step();
    @(negedge clock);
    check("tag0_idle_after", cdb_packet_out, '0);

    // Full contention from a fresh rr_ptr: grants must rotate 0,1,2,3,...
    do_reset();
    for (int i = 0; i < NCH; i++) seq[i] = 0;
    for (int r = 0; r < 2; r++) for (int i = 0; i < NCH; i++) exp_grant.push_back(i);
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!fu_valid[i]) begin
          offer(i, TAG_W'(i * 8 + seq[i]), 32'hA000_0000 | (i << 16) | seq[i]);
          seq[i]++;
        end
      end
      step();
    end
    fu_valid = '0;
    drain("contention_drain");
    check("contention_grants_seen", exp_grant.size(), 0);

    // Reset mid-burst.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NCH; i++) if (!fu_valid[i]) offer(i, TAG_W'(c + i), 32'h5500 + c);
      step();
    end
    do_reset();

    // Channel 1 overloaded while 0 and 3 compete: it must fill and back-pressure.
    saw_full = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (!fu_valid[0]) offer(0, TAG_W'(c), 32'h0C00 + c);
      if (!fu_valid[1]) offer(1, TAG_W'(c + 8), 32'h1C00 + c);
      if (!fu_valid[3]) offer(3, TAG_W'(c + 16), 32'h3C00 + c);
      if (!fu_ready[1]) saw_full = 1'b1;
      step();
    end
    check("ch1_full_seen", {63'd0, saw_full}, 64'd1);
    for (int c = 0; c < 20 && fu_valid != '0; c++) step();
    check("held_inputs_taken", fu_valid, '0);
    drain("full_drain");

    // Squash with buffered and newly offered results; none may be broadcast.
    do_reset();
    for (int i = 0; i < NCH; i++) offer(i, TAG_W'(10 + i), 32'h5A00 + i);
    step();
    step();
    squash = 1'b1;
    offer(2, 5'd20, 32'h5A20);
    offer(3, 5'd21, 32'h5A21);
    step();
    @(negedge clock);
    check("squash_out_invalid", cdb_packet_out.reg_tag.valid, 1'b0);
    check("squash_ready", fu_ready, 4'hF);
    for (int i = 0; i < NCH; i++) exp_grant.push_back(i);
    for (int i = 0; i < NCH; i++) offer(i, TAG_W'(24 + i), 32'h6B00 + i);
    step();
    drain("squash_drain");
    check("squash_rr_restart", exp_grant.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Completion-side producer of the common data bus. It accepts finished results from the functional-unit channels, buffers them per channel, and picks one result per cycle by round-robin. The winner is driven as a registered `CDB_PACKET` that every RS entry, the map table and the ROB snoop. It is the transmitter of the tag/value broadcast that RS entries use to wake operands.

## Interface
Parameters:
- `NUM_CH`, default 4: number of functional-unit completion channels.
- `FIFO_DEPTH`, default 2: entries per channel buffer (power of two, ≥2).

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `squash`  in  1: synchronous flush from branch recovery, active-high.
- `fu_valid`  in  `NUM_CH`: channel i presents a completed result.
- `fu_tag`  in  `NUM_CH` × `$clog2(ROB_LEN)`: ROB tag of the result.
- `fu_value`  in  `NUM_CH` × `XLEN`: result value.
- `fu_ready`  out  `NUM_CH`: channel i can accept this cycle.
- `cdb_packet_out`  out  `CDB_PACKET`: `reg_tag.tag`, `reg_tag.valid`, `reg_value`.
- `grant_ch`  out  `$clog2(NUM_CH)`: channel that produced the current broadcast (debug and perf).

## Operation
- **Accept.** Channel i is accepted when `fu_valid[i] && fu_ready[i]`, and the {tag, value} pair is pushed into FIFO i.
- **Ready.** `fu_ready[i] = (count_i < FIFO_DEPTH)`. It depends on registered state only; there is no combinational path from the grant to the ready signal.
- **Candidates.** Channel i is a candidate when FIFO i is non-empty.
- **Arbitration.** Round-robin pointer `rr_ptr`. The winner is the first candidate scanning upward from `rr_ptr`, modulo `NUM_CH`.
- **Pointer update.**
  - On a grant, `rr_ptr <= winner + 1` (mod `NUM_CH`).
  - With no candidate, `rr_ptr` holds.
- **Grant.** The winner's FIFO head is popped. The output register is loaded with `reg_tag.valid = 1`, `reg_tag.tag = head tag`, `reg_value = head value`, and `grant_ch = winner`.
- **Idle.** With no candidate, the output register loads tag 0, valid 0, value 0. `grant_ch` holds its last value.
- **Tag 0.** Tag 0 is a legal ROB tag; consumers qualify matches on `reg_tag.valid`.
- **Push and pop together.** A simultaneous push and pop on the same FIFO leaves its count unchanged; the FIFO stays ordered.
- **Full FIFO.** With `fu_ready = 0`, the channel must hold `fu_valid` and its data. Any input offered while not ready is ignored.
- **Squash.**
  - Next edge: all FIFOs are emptied, `rr_ptr <= 0`, and the output register is cleared to valid 0.
  - Inputs offered in the squash cycle are dropped.
  - The broadcast visible during the squash cycle still completes normally.
- **Reset.** Asserting `reset` at any time, including mid-burst, immediately clears all FIFOs, `rr_ptr`, and the output register to zero.
- **Reset values.** `cdb_packet_out = '0` (tag 0, valid 0, value 0), `grant_ch = 0`, and `fu_ready = all ones` once out of reset.

## Timing
- **Base latency: 2 cycles.** A result accepted at edge N is at the FIFO head during cycle N+1. If it wins, it is visible on `cdb_packet_out` after edge N+1.
- **Broadcast duration.** Each broadcast is valid for exactly one cycle. RS entries sample it on the following edge.
- **Throughput.** At most one broadcast per cycle. Under full contention each channel gets one grant every `NUM_CH` cycles.
- **Back-pressure.** A channel that is constantly offered results and always granted never deasserts `fu_ready` when `FIFO_DEPTH ≥ 2`.

## Configuration
- **`CDB_BYPASS_EN` defined:**
  - A channel whose FIFO is empty and whose `fu_valid` is high is also a candidate in that same cycle.
  - If it wins, its input goes straight into the output register and is not enqueued, so latency is 1 cycle.
  - Priority order is unchanged; bypassing never reorders results within a channel.
- **`CDB_BYPASS_EN` undefined:** all results pass through the FIFO, and latency is always 2 cycles.

## Structure
- **Shared `sys_defs.svh`:**
  - `TAG_PACKET` and `CDB_PACKET` typedefs, already shared with RS/MT/ROB.
  - New constants `CDB_NUM_CH` and `CDB_FIFO_DEPTH`, used as the defaults here.
  - A `CDB_ENTRY` typedef {tag, value} for FIFO storage.
- **Sub-module `cdb_fifo`:** a parameterized depth-N synchronous FIFO with a count output, the same async active-low reset, and a synchronous `flush`. It is instantiated `NUM_CH` times.
- **Top level:** arbitration, `rr_ptr` and the output register live in `cdb_broadcaster`.

## Test plan
- **Reset.** Assert `reset` low mid-run, then release → `cdb_packet_out` is tag 0/valid 0/value 0, `grant_ch = 0`, and `fu_ready = 4'b1111` the cycle after release.
- **Single result.** `fu_valid[2]` with tag 5, value 0xDEAD for one cycle → broadcast {tag 5, valid 1, value 0xDEAD} visible 2 edges later (1 edge with `CDB_BYPASS_EN`), valid for exactly 1 cycle.
- **All channels every cycle.** All 4 channels offer results every cycle → grants rotate 0,1,2,3,0,… and no result is lost or duplicated. A scoreboard compares the per-channel order.
- **Full FIFO.** Channel 1 fills to depth 2 while channels 0 and 3 win → `fu_ready[1] = 0`. A held input is accepted after the next pop; order is preserved.
- **Squash.** Assert `squash` with 3 buffered results plus 2 new inputs → next cycle the output is valid 0 and all FIFOs are empty. None of the 5 results is ever broadcast, and `rr_ptr` restarts at 0.
- **Tag 0.** Result with tag 0, value 7 → broadcast shows tag 0 with `reg_tag.valid = 1`. The idle cycles around it show valid 0.
